// File: rtl/rr_arb4.sv
// Four-way round-robin arbiter with a release gap between grants.
// Optional grant timeout is enabled by defining RR_ARB4_TIMEOUT_EN (adds the tmo output).
module rr_arb4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       en,
  output logic [1:0] ptr,
  output logic [1:0] state_dbg
`ifdef RR_ARB4_TIMEOUT_EN
  ,
  output logic       tmo
`endif
);

  // Handshake: a requester raises req[k] and holds it; gnt[k] is its grant.
  // The owner keeps the grant until it pulses done or drops req[k].
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] sel_d, ptr_d;
  logic       en_d;
  logic [1:0] pick_idx;
  logic [1:0] idx;
  logic       found;
  logic       tmo_hit;
  logic       release_now;

  // First set request bit scanning upward from ptr, wrapping mod 4.
  always_comb begin
    found    = 1'b0;
    pick_idx = ptr;
    idx      = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        pick_idx = idx;
        found    = 1'b1;
      end
    end
  end

`ifdef RR_ARB4_TIMEOUT_EN
  logic [3:0] cnt_q;
  logic       tmo_q;

  assign tmo_hit = (state_q == GRANT) && (cnt_q == 4'd15);
  assign tmo     = tmo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
      tmo_q <= 1'b0;
    end else begin
      tmo_q <= tmo_hit;
      if (state_q == IDLE && found) cnt_q <= 4'd0;
      else if (state_q == GRANT)    cnt_q <= cnt_q + 4'd1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // done, a dropped request and a timeout all collapse into one release.
  assign release_now = done | ~req[sel] | tmo_hit;

  always_comb begin
    state_d = state_q;
    sel_d   = sel;
    en_d    = en;
    ptr_d   = ptr;
    case (state_q)
      IDLE: begin
        if (found) begin
          sel_d   = pick_idx;
          en_d    = 1'b1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (release_now) begin
          en_d    = 1'b0;
          ptr_d   = sel + 2'd1;
          state_d = GAP;
        end
      end
      GAP: begin
        en_d    = 1'b0;
        state_d = IDLE;
      end
      default: begin
        en_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel     <= 2'd0;
      en      <= 1'b0;
      ptr     <= 2'd0;
    end else begin
      state_q <= state_d;
      sel     <= sel_d;
      en      <= en_d;
      ptr     <= ptr_d;
    end
  end

  // Decoded from registers only, so reset removes the grant asynchronously.
  always_comb begin
    gnt = 4'b0000;
    if (en) gnt[sel] = 1'b1;
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_rr_arb4.sv
// Directed table-driven bench for rr_arb4 plus hand-written reset and timeout sequences.
module tb_rr_arb4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       en;
  logic [1:0] ptr;
  logic [1:0] state_dbg;
`ifdef RR_ARB4_TIMEOUT_EN
  logic       tmo;
`endif

  rr_arb4 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .done     (done),
    .gnt      (gnt),
    .sel      (sel),
    .en       (en),
    .ptr      (ptr),
    .state_dbg(state_dbg)
`ifdef RR_ARB4_TIMEOUT_EN
    ,
    .tmo      (tmo)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [1:0] S_IDLE = 2'd0, S_GRANT = 2'd1, S_GAP = 2'd2;

  typedef struct packed {
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       en;
    logic [1:0] ptr;
    logic [1:0] st;
  } vec_t;

  vec_t        vecs[$];
  logic [10:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  function automatic void add(input logic [3:0] r, input logic d, input logic [3:0] g,
                              input logic [1:0] s, input logic e, input logic [1:0] p,
                              input logic [1:0] st);
    vec_t v;
    v.req = r; v.done = d; v.gnt = g; v.sel = s; v.en = e; v.ptr = p; v.st = st;
    vecs.push_back(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [10:0] exp);
    logic [10:0] got;
    got = {gnt, sel, en, ptr, state_dbg};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got gnt=%b sel=%0d en=%b ptr=%0d st=%0d, expected gnt=%b sel=%0d en=%b ptr=%0d st=%0d",
               name, got[10:7], got[6:5], got[4], got[3:2], got[1:0],
               exp[10:7], exp[6:5], exp[4], exp[3:2], exp[1:0]);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  initial begin
    logic [1:0] s;
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    #12;
    check("reset", {4'b0000, 2'd0, 1'b0, 2'd0, S_IDLE});
    @(negedge clk);
    rst_n = 1'b1;

    // All four requesting, done during each grant's 3rd cycle: 0,1,2,3,0.
    for (int g = 0; g < 5; g++) begin
      s = 2'(g % 4);
      add(4'hF, 1'b0, 4'b0001 << s, s, 1'b1, s, S_GRANT);
      add(4'hF, 1'b0, 4'b0001 << s, s, 1'b1, s, S_GRANT);
      add(4'hF, 1'b0, 4'b0001 << s, s, 1'b1, s, S_GRANT);
      add(4'hF, 1'b1, 4'b0000,      s, 1'b0, s + 2'd1, S_GAP);
      add(4'hF, 1'b0, 4'b0000,      s, 1'b0, s + 2'd1, S_IDLE);
    end
    // Owner 1 keeps grant while other requests arrive; then 2 is served.
    add(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 2'd1, S_GRANT);
    add(4'b1110, 1'b0, 4'b0010, 2'd1, 1'b1, 2'd1, S_GRANT);
    add(4'b1110, 1'b0, 4'b0010, 2'd1, 1'b1, 2'd1, S_GRANT);
    add(4'b1110, 1'b1, 4'b0000, 2'd1, 1'b0, 2'd2, S_GAP);
    add(4'b1110, 1'b0, 4'b0000, 2'd1, 1'b0, 2'd2, S_IDLE);
    add(4'b1110, 1'b0, 4'b0100, 2'd2, 1'b1, 2'd2, S_GRANT);
    // Owner drops its request without done; done in GAP/IDLE ignored.
    add(4'b1010, 1'b0, 4'b0000, 2'd2, 1'b0, 2'd3, S_GAP);
    add(4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 2'd3, S_IDLE);
    add(4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 2'd3, S_IDLE);
    add(4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 2'd3, S_IDLE);
    // Wrap search from ptr 3 to requester 1; simultaneous done and drop.
    add(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 2'd3, S_GRANT);
    add(4'b0000, 1'b1, 4'b0000, 2'd1, 1'b0, 2'd2, S_GAP);
    // ptr=2, req=0011: requests seen in GAP are ignored, then wrap to 0.
    add(4'b0011, 1'b0, 4'b0000, 2'd1, 1'b0, 2'd2, S_IDLE);
    add(4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1, 2'd2, S_GRANT);
    add(4'b0011, 1'b1, 4'b0000, 2'd0, 1'b0, 2'd1, S_GAP);
    add(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 2'd1, S_IDLE);

    for (int i = 0; i < vecs.size(); i++) begin
      req  = vecs[i].req;
      done = vecs[i].done;
      exp_q.push_back({vecs[i].gnt, vecs[i].sel, vecs[i].en, vecs[i].ptr, vecs[i].st});
      tick();
      check($sformatf("vec%0d", i), exp_q.pop_front());
    end

    // Asynchronous reset between clock edges while a grant is held.
    req = 4'b0100; done = 1'b0;
    tick();
    check("pre_rst_grant", {4'b0100, 2'd2, 1'b1, 2'd1, S_GRANT});
    tick();
    check("pre_rst_hold", {4'b0100, 2'd2, 1'b1, 2'd1, S_GRANT});
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", {4'b0000, 2'd0, 1'b0, 2'd0, S_IDLE});
    tick();
    check("rst_held", {4'b0000, 2'd0, 1'b0, 2'd0, S_IDLE});
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b0000;
    tick();
    check("post_rst_idle", {4'b0000, 2'd0, 1'b0, 2'd0, S_IDLE});
    req = 4'b1000;
    tick();
    check("post_rst_first", {4'b1000, 2'd3, 1'b1, 2'd0, S_GRANT});
    done = 1'b1;
    tick();
    check("wrap_ptr", {4'b0000, 2'd3, 1'b0, 2'd0, S_GAP});
    done = 1'b0;
    req  = 4'b0000;
    tick();

`ifdef RR_ARB4_TIMEOUT_EN
    // Single requester never releases: 16 grant cycles, tmo pulse, gap, regrant.
    req = 4'b0001;
    for (int c = 0; c < 16; c++) begin
      tick();
      check($sformatf("tmo_hold%0d", c), {4'b0001, 2'd0, 1'b1, 2'd0, S_GRANT});
      check_bit($sformatf("tmo_low%0d", c), tmo, 1'b0);
    end
    tick();
    check("tmo_gap", {4'b0000, 2'd0, 1'b0, 2'd1, S_GAP});
    check_bit("tmo_pulse", tmo, 1'b1);
    tick();
    check("tmo_idle", {4'b0000, 2'd0, 1'b0, 2'd1, S_IDLE});
    check_bit("tmo_clear", tmo, 1'b0);
    tick();
    check("tmo_regrant", {4'b0001, 2'd0, 1'b1, 2'd1, S_GRANT});
    req = 4'b0000;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rr_arb4.md
RR_ARB4 -- requirements
Module: rr_arb4

Interface
REQ-001 The block SHALL have ports clk input 1 (rising-edge clock); one clock only.
REQ-002 The block SHALL have port rst_n input 1; reset is asynchronous and active-low.
REQ-003 The block SHALL have port req input 4 (request; bit k = requester k).
REQ-004 The block SHALL have port done input 1 (current owner releases the resource).
REQ-005 The block SHALL have port gnt output 4 (one-hot grant, 2-to-4 decoded from sel gated by en).
REQ-006 The block SHALL have port sel output 2 (encoded index of granted requester).
REQ-007 The block SHALL have port en output 1 (decoder enable; 1 while a grant is held).
REQ-008 The block SHALL have port ptr output 2 (current round-robin priority pointer).

Function
REQ-009 The block SHALL implement states IDLE, GRANT, GAP; all outputs registered or decoded from registers only.
REQ-010 IDLE: if req != 0, the block SHALL select the first set bit scanning ptr, ptr+1, ... mod 4, load sel, go GRANT.
REQ-011 The block SHALL assert gnt one cycle after req is sampled in IDLE (latency 1 clock).
REQ-012 The block SHALL drive gnt[k] = en & (sel == k); gnt SHALL be all-zero when en = 0, never more than one bit set.
REQ-013 GRANT: the block SHALL hold sel and en = 1 while req[sel] = 1 and done = 0, regardless of other req bits.
REQ-014 GRANT: on done = 1 or req[sel] = 0, the block SHALL go GAP, clear en, and set ptr = sel + 1 mod 4 (3 wraps to 0).
REQ-015 GAP: the block SHALL hold en = 0 exactly one cycle, then go IDLE; req is ignored in GAP.
REQ-016 done SHALL be ignored in IDLE and GAP.
REQ-017 Simultaneous done = 1 and req[sel] = 0 SHALL be treated as a single release.
REQ-018 IDLE with req = 0 SHALL remain IDLE with en = 0, sel and ptr unchanged.
REQ-019 Requests from all four requesters held continuously SHALL be served in order 0,1,2,3,0,... after reset.

Reset
REQ-020 On rst_n = 0 the block SHALL asynchronously enter IDLE with sel = 0, ptr = 0, en = 0, gnt = 0000.
REQ-021 Reset asserted during GRANT SHALL remove gnt immediately, without waiting for a clock edge.
REQ-022 After rst_n deasserts, the first grant decision SHALL occur on the first rising clk edge with req != 0.

Configuration
REQ-023 With macro RR_ARB4_TIMEOUT_EN defined, the block SHALL count GRANT cycles in a 4-bit counter cleared on entry to GRANT.
REQ-024 With RR_ARB4_TIMEOUT_EN defined, a grant held 16 cycles SHALL be released as if done = 1 and output tmo (1 bit) SHALL pulse high for that one cycle.
REQ-025 Without RR_ARB4_TIMEOUT_EN, the counter and tmo port SHALL not exist and a grant SHALL be held indefinitely per REQ-013.

Verification
REQ-026 Reset, req = 1111 held, done pulsed on each grant's 3rd cycle -> sel sequence 0,1,2,3,0 with a single en = 0 gap between grants.
REQ-027 ptr = 2, req = 0011 in IDLE -> sel = 0 (wrap search), gnt = 0001 next cycle, ptr = 1 after release.
REQ-028 Grant to 1 held, req changes 0010 -> 1110 -> gnt stays 0010 until done; then GAP, then gnt = 0100.
REQ-029 rst_n driven low mid-GRANT between clk edges -> gnt = 0000, en = 0 immediately; sel = 0, ptr = 0.
REQ-030 Owner drops req[sel] with done = 0 -> release next edge, ptr = sel + 1; done pulse in IDLE -> no effect.
REQ-031 RR_ARB4_TIMEOUT_EN defined, req = 0001 held, done = 0 -> gnt = 0001 for 16 cycles, tmo pulse, GAP, regrant to 0.
